arinc_word_seq: RTL and testbench

Parametrised ARINC 429 word source for one transmit channel. It holds a table of N_WORDS label/data entries, each writable at run time, and scans them in index order. Each enabled entry is presented as a registered word (speed code, label, 23-bit data, odd parity) to the ARINC transmitter over a valid/ready handshake, with a programmable idle gap between words. It replaces fixed single-word constant sources and supports one-shot and continuous sequencing.

---
 rtl/arinc_pkg.sv | 13 +
 rtl/arinc_word_tab.sv | 21 ++
 rtl/arinc_word_seq.sv | 138 +++++++++++++
 tb/tb_arinc_word_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arinc_pkg.sv
// arinc_pkg: shared ARINC 429 word-source types, field widths and speed codes
package arinc_pkg;
  localparam int LAB_W = 8;
  localparam int DAT_W = 23;
  localparam logic [1:0] VEL_100K = 2'b10;
  localparam logic [1:0] VEL_12K5 = 2'b00;
  typedef enum logic [2:0] {IDLE, SCAN, PRESENT, GAP, ADV} state_t;
  typedef struct packed {
    logic act;
    logic [LAB_W-1:0] lab;
    logic [DAT_W-1:0] dat;
  } entry_t;
endpackage

// File: rtl/arinc_word_tab.sv
// arinc_word_tab: label/data entry table, one write port, asynchronous read port
module arinc_word_tab import arinc_pkg::*; #(
  parameter int N_WORDS = 4,
  localparam int IW = $clog2(N_WORDS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic [IW-1:0] wr_idx,
  input  entry_t wr_ent,
  input  logic [IW-1:0] rd_idx,
  output entry_t rd_ent
);
  entry_t tab [N_WORDS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < N_WORDS; i++) tab[i] <= '0;
    else if (wr_en && 32'(wr_idx) < N_WORDS)
      tab[wr_idx] <= wr_ent;
  assign rd_ent = tab[rd_idx];
endmodule

// File: rtl/arinc_word_seq.sv
// arinc_word_seq: scans the entry table and presents each enabled word over valid/ready
module arinc_word_seq import arinc_pkg::*; #(
  parameter int N_WORDS = 4,
  parameter int GAP_CYC = 4,
  parameter logic [1:0] DEF_VEL = VEL_100K,
  localparam int IW = $clog2(N_WORDS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic wr_act,
  input  logic [LAB_W-1:0] wr_lab,
  input  logic [DAT_W-1:0] wr_dat,
  input  logic vel_wr,
  input  logic [1:0] vel_in,
  input  logic start,
  input  logic cont,
  input  logic stop,
  input  logic tx_ready,
  output logic tx_valid,
  output logic [1:0] VEL,
  output logic [LAB_W-1:0] ADR,
  output logic [DAT_W-1:0] DAT,
  output logic PAR,
  output logic busy,
  output logic done
);
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, ptr_inc;
  logic [IW:0] scnt, scnt_n;
  logic [7:0] gcnt, gcnt_n;
  logic mode, mode_n, stop_f, stop_f_n, done_n, latch, last, stp;
  logic [1:0] vel_r;
  entry_t cur;
  arinc_word_tab #(.N_WORDS(N_WORDS)) u_tab (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_ent({wr_act, wr_lab, wr_dat}), .rd_idx(ptr), .rd_ent(cur)
  );
  assign last = ptr == IW'(N_WORDS - 1);
  assign ptr_inc = last ? '0 : ptr + 1'b1;
  assign stp = stop | stop_f;
  assign tx_valid = state == PRESENT;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    scnt_n = scnt;
    gcnt_n = gcnt;
    mode_n = mode;
    stop_f_n = stop_f | stop;
    done_n = 1'b0;
    latch = 1'b0;
    case (state)
      IDLE: begin
        stop_f_n = 1'b0;
        if (start) begin
          state_n = SCAN;
          ptr_n = '0;
          scnt_n = '0;
          mode_n = cont;
        end
      end
      SCAN:
        if (stp) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else if (cur.act) begin
          state_n = PRESENT;
          latch = 1'b1;
          scnt_n = '0;
        // a full lap of inactive entries, or the end of a one-shot pass
        end else if (scnt == (IW+1)'(N_WORDS - 1) || (last && !mode)) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else begin
          ptr_n = ptr_inc;
          scnt_n = scnt + 1'b1;
        end
      PRESENT:
        if (tx_ready) begin
          if (stp) begin
            state_n = IDLE;
            done_n = 1'b1;
          end else if (GAP_CYC == 0) state_n = ADV;
          else begin
            state_n = GAP;
            gcnt_n = 8'(GAP_CYC - 1);
          end
        end
      GAP:
        if (stp) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else if (gcnt == '0) state_n = ADV;
        else gcnt_n = gcnt - 1'b1;
      ADV:
        if (stp || (last && !mode)) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else begin
          ptr_n = ptr_inc;
          state_n = SCAN;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      scnt <= '0;
      gcnt <= '0;
      mode <= 1'b0;
      stop_f <= 1'b0;
      done <= 1'b0;
      vel_r <= DEF_VEL;
      VEL <= DEF_VEL;
      ADR <= '0;
      DAT <= '0;
      PAR <= 1'b1;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      scnt <= scnt_n;
      gcnt <= gcnt_n;
      mode <= mode_n;
      stop_f <= stop_f_n;
      done <= done_n;
      vel_r <= vel_wr ? vel_in : vel_r;
      if (latch) begin
        VEL <= vel_r;
        ADR <= cur.lab;
        DAT <= cur.dat;
        PAR <= ~^{cur.lab, cur.dat};
      end
    end
endmodule

// File: tb/tb_arinc_word_seq.sv
// tb_arinc_word_seq: vector table, random passes against a word-list model, corner sequences
module tb_arinc_word_seq;
  import arinc_pkg::*;
  localparam int N = 4, G = 4;
  logic clk = 0, rst_n = 0, wr_en = 0, wr_act = 0, vel_wr = 0;
  logic start = 0, cont = 0, stop = 0, tx_ready = 0;
  logic [1:0] wr_idx = 0, vel_in = 0;
  logic [7:0] wr_lab = 0;
  logic [22:0] wr_dat = 0;
  logic tx_valid, PAR, busy, done;
  logic [1:0] VEL;
  logic [7:0] ADR;
  logic [22:0] DAT;
  int errs = 0, checks = 0;
  logic m_act [N];
  logic [7:0] m_lab [N];
  logic [22:0] m_dat [N];
  logic [1:0] m_vel = VEL_100K;
  typedef struct {
    logic [3:0] act;
    logic [7:0] lab0;
    logic [22:0] dat0;
    int exp_lat;
    int exp_n;
  } vec_t;
  vec_t vt [5];
  int lat, n, first, c;
  int rise [$];
  logic [7:0] adrs [$];
  logic [30:0] words [$];
  logic pv;
  always #5 clk = ~clk;
  arinc_word_seq #(.N_WORDS(N), .GAP_CYC(G), .DEF_VEL(VEL_100K)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_act(wr_act),
    .wr_lab(wr_lab), .wr_dat(wr_dat), .vel_wr(vel_wr), .vel_in(vel_in),
    .start(start), .cont(cont), .stop(stop), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .VEL(VEL), .ADR(ADR), .DAT(DAT), .PAR(PAR),
    .busy(busy), .done(done)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int i, input logic a, input logic [7:0] l, input logic [22:0] d);
    wr_en = 1; wr_idx = i[1:0]; wr_act = a; wr_lab = l; wr_dat = d;
    step;
    wr_en = 0;
    m_act[i] = a; m_lab[i] = l; m_dat[i] = d;
  endtask
  // one-shot pass: accepted words must be the active entries in index order
  task automatic run_pass(input int pct, output int lat_o, output int n_o);
    int exp_idx [$];
    int k, cnt;
    logic held;
    logic [31:0] hold_w;
    for (int i = 0; i < N; i++) if (m_act[i]) exp_idx.push_back(i);
    n_o = 0; lat_o = -1; held = 0; hold_w = 0;
    cont = 0; start = 1;
    step;
    start = 0;
    chk("busy_after_start", busy, 1);
    for (cnt = 1; cnt < 400 && !done; cnt++) begin
      if (tx_valid && lat_o < 0) lat_o = cnt;
      if (tx_valid && held) chk("hold_word", {ADR, DAT, PAR}, hold_w);
      tx_ready = $urandom_range(99) < pct;
      if (tx_valid && tx_ready) begin
        if (n_o < exp_idx.size()) begin
          k = exp_idx[n_o];
          chk("word_adr", ADR, m_lab[k]);
          chk("word_dat", DAT, m_dat[k]);
          chk("word_par", PAR, ($countones({m_lab[k], m_dat[k]}) % 2) == 0);
          chk("word_vel", VEL, m_vel);
        end
        n_o++;
      end
      held = tx_valid && !tx_ready;
      hold_w = {ADR, DAT, PAR};
      step;
    end
    tx_ready = 0;
    if (lat_o < 0) lat_o = cnt;
    chk("pass_done", done, 1);
    chk("pass_words", n_o, exp_idx.size());
    step;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin m_act[i] = 0; m_lab[i] = 0; m_dat[i] = 0; end
    vt[0] = '{4'b0101, 8'h84, 23'h1ffaab, 2, 2};
    vt[1] = '{4'b1000, 8'h10, 23'h000100, 5, 1};
    vt[2] = '{4'b0000, 8'h20, 23'h7fffff, 5, 0};
    vt[3] = '{4'b1111, 8'hfe, 23'h2aaaaa, 2, 4};
    vt[4] = '{4'b0010, 8'h01, 23'h000000, 3, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_adr", ADR, 0);
    chk("rst_dat", DAT, 0);
    chk("rst_par", PAR, 1);
    chk("rst_vel", VEL, VEL_100K);
    rst_n = 1;
    step;
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < N; i++) wr(i, vt[v].act[i], vt[v].lab0 + 8'(i), vt[v].dat0 ^ 23'(i));
      run_pass(60, lat, n);
      chk($sformatf("vec%0d_lat", v), lat, vt[v].exp_lat);
      chk($sformatf("vec%0d_n", v), n, vt[v].exp_n);
    end
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) wr(i, 1'($urandom_range(1)), 8'($urandom), 23'($urandom));
      if (r % 3 == 1) begin
        vel_in = 2'($urandom); vel_wr = 1;
        step;
        vel_wr = 0; m_vel = vel_in;
      end
      first = -1;
      for (int i = N - 1; i >= 0; i--) if (m_act[i]) first = i;
      run_pass(int'($urandom_range(30, 100)), lat, n);
      chk("rand_lat", lat, first < 0 ? 5 : 2 + first);
    end
    wr(0, 1, 8'h84, 23'h1ffaab); wr(1, 0, 0, 0); wr(2, 1, 8'h85, 23'h000001); wr(3, 0, 0, 0);
    cont = 1; start = 1; tx_ready = 1;
    step;
    start = 0; cont = 0; pv = 0;
    for (c = 0; c < 100 && rise.size() < 4; c++) begin
      if (tx_valid && !pv) begin rise.push_back(c); adrs.push_back(ADR); end
      pv = tx_valid;
      step;
    end
    chk("cont_count", rise.size(), 4);
    for (int i = 0; i < rise.size(); i++) chk("cont_adr", adrs[i], i % 2 ? 8'h85 : 8'h84);
    for (int i = 1; i < rise.size(); i++) chk("cont_spacing", rise[i] - rise[i-1], 1 + G + 1 + 1 + 1);
    stop = 1;
    step;
    stop = 0;
    for (c = 0; c < 10 && !done; c++) step;
    chk("cont_stop_done", done, 1);
    tx_ready = 0;
    step;
    cont = 1; start = 1;
    step;
    start = 0; cont = 0;
    for (c = 0; c < 20 && !tx_valid; c++) step;
    chk("bp_valid", tx_valid, 1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_held_dat", DAT, 23'h1ffaab);
      chk("bp_held_valid", tx_valid, 1);
      if (i == 5) wr(0, 1, 8'h84, 23'h112200);
      else step;
    end
    tx_ready = 1;
    for (c = 0; c < 60 && words.size() < 2; c++) begin
      if (tx_valid) words.push_back({ADR, DAT});
      step;
    end
    tx_ready = 0;
    chk("bp_words", words.size(), 2);
    if (words.size() == 2) begin
      chk("bp_first", words[0], {8'h84, 23'h1ffaab});
      chk("bp_second", words[1], {8'h85, 23'h000001});
    end
    for (c = 0; c < 20 && !tx_valid; c++) step;
    chk("bp_new_dat", DAT, 23'h112200);
    stop = 1;
    step;
    stop = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stop_hold_valid", tx_valid, 1);
      step;
    end
    tx_ready = 1;
    step;
    tx_ready = 0;
    chk("stop_done", done, 1);
    chk("stop_valid", tx_valid, 0);
    chk("stop_busy", busy, 0);
    step;
    vel_in = VEL_12K5; vel_wr = 1;
    step;
    vel_wr = 0;
    start = 1;
    step;
    start = 0;
    for (c = 0; c < 20 && !tx_valid; c++) step;
    chk("vel_new", VEL, VEL_12K5);
    rst_n = 0;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_vel", VEL, VEL_100K);
    chk("arst_adr", ADR, 0);
    chk("arst_busy", busy, 0);
    #2 rst_n = 1;
    step;
    for (int i = 0; i < N; i++) begin m_act[i] = 0; m_lab[i] = 0; m_dat[i] = 0; end
    m_vel = VEL_100K;
    run_pass(100, lat, n);
    chk("arst_table_lat", lat, 5);
    chk("arst_table_n", n, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
